rob_commit: RTL and testbench
=============================

Name: rob_commit

Overview:
- In-order reorder buffer and commit unit that receives renamed instructions from the rename stage.
- Tracks their writeback completion from execution and retires them in program order.
- Drives the in-order physical-register commit stream (p_reg_t) back into rename's p_commit_i.
- Handles a single outstanding branch: on misprediction it squashes every younger entry, mirroring rename's single checkpoint.

Parameters:
DEPTH, 16, number of ROB entries; power of two, >= 4.
PTR_W, $clog2(DEPTH), head/tail pointer width (derived, not overridable).

Ports:
clk_i  input  1  clock, rising edge.
rst_ni  input  1  reset, asynchronous, active-low.
rinstr_i  input  rinstr_t  renamed instruction from rename; enqueued when .valid and !rob_full_o.
is_branch_i  input  1  qualifies rinstr_i as a branch.
wb_i  input  p_reg_t  execution writeback: .valid plus physical destination .idx.
br_result_i  input  br_result_t  branch resolution: .valid, .hit (1 = predicted correctly).
p_commit_o  output  p_reg_t  registered in-order commit of a physical destination.
rob_full_o  output  1  combinational: count == DEPTH.
rob_empty_o  output  1  combinational: count == 0.
commit_cnt_o  output  32  retired-instruction counter (optional feature).
flush_cnt_o  output  32  squashed-entry counter (optional feature).

Behaviour:
- Entry fields: valid, done, has_rd, pdest[5:0], is_br. Circular buffer with head, tail (PTR_W bits) and count (PTR_W+1 bits); pointers wrap DEPTH-1 -> 0.
- Reset: all entries invalid; head = tail = count = 0; p_commit_o = '0; rob_full_o = 0; rob_empty_o = 1; branch tracking clear; counters 0.
- Enqueue (edge where rinstr_i.valid && !rob_full_o && no mispredict this cycle):
  - Write entry at tail and increment tail.
  - has_rd = rd.valid && rd.idx != 0; pdest = rd.idx.
  - done = !has_rd && !is_branch_i.
  - For a branch, store br_idx = tail and set br_pending.
  - Full blocks enqueue even when a commit occurs in the same cycle (conservative).
- Writeback: wb_i.valid sets done on every valid entry with has_rd && pdest == wb_i.idx (CAM). No match: ignored.
- Branch resolve (br_result_i.valid && br_pending):
  - Set done on entry br_idx and clear br_pending.
  - If !hit: invalidate all entries younger than br_idx, set tail = br_idx+1, and recompute count. A same-cycle enqueue is dropped. A same-cycle writeback to a squashed entry has no effect.
- br_result_i.valid with !br_pending: ignored.
- Commit: one entry per cycle when head entry is valid && done.
  - At that edge: invalidate head, increment head, decrement count.
  - p_commit_o.valid = has_rd, p_commit_o.idx = pdest (registered, visible for exactly one cycle after the pop edge); otherwise p_commit_o.valid = 0.
- Latency: wb sampled at edge E -> done at E -> pop at E+1 -> p_commit_o valid in the cycle after E+1, provided the entry is at head.
- Simultaneous enqueue + commit (not full): count unchanged. Enqueue + commit + squash: squash recount uses the post-commit head.
- A mispredicting branch at head cannot retire in the same cycle it resolves; it retires the following cycle.
- Reset mid-operation returns immediately to reset state; in-flight entries are lost.

Optional Feature:
ROB_PERF_CNT_EN
- Defined: commit_cnt_o increments on every retired entry; flush_cnt_o adds the number of entries squashed per mispredict. Both are 32-bit wrapping counters, reset to 0.
- Undefined: both outputs are tied to 0 and no counter flops are synthesised.

Test Plan:
- Enqueue p33 (rd), p34 (rd), an instruction without rd; wb p34 then p33 -> p_commit_o shows idx 33 then 34 on consecutive cycles; the no-rd entry retires silently with valid=0; rob_empty_o=1 afterwards.
- Enqueue 16 rd instructions with no wb -> rob_full_o=1; 17th rinstr_i is not accepted; wb head entry -> one pop, then next enqueue accepted, tail wraps to 1.
- Enqueue p40, branch, p41, p42; br_result_i {valid=1, hit=0} -> count=2, tail=br_idx+1; later wb p41 ignored; wb p40 -> p40 commits, branch retires, then empty.
- Same scenario with hit=1 -> nothing squashed; wb p40/p41/p42 -> commits 40, 41, 42 in order.
- Assert rst_ni low with 5 entries in flight -> next cycle count=0, rob_empty_o=1, p_commit_o.valid=0.
- With ROB_PERF_CNT_EN: 10 commits + 3-entry squash -> commit_cnt_o=10, flush_cnt_o=3; without the macro both read 0.

Source files
------------

// File: rtl/rob_commit.sv
// In-order reorder buffer / commit unit with single-branch squash support.
// Optional ROB_PERF_CNT_EN adds 32-bit retire and squash counters.
package rob_commit_pkg;
  typedef struct packed {
    logic       valid;
    logic [5:0] idx;
  } p_reg_t;

  typedef struct packed {
    logic   valid;
    p_reg_t rd;
  } rinstr_t;

  typedef struct packed {
    logic valid;
    logic hit;
  } br_result_t;
endpackage

module rob_commit
  import rob_commit_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  rinstr_t     rinstr_i,
  input  logic        is_branch_i,
  input  p_reg_t      wb_i,
  input  br_result_t  br_result_i,
  output p_reg_t      p_commit_o,
  output logic        rob_full_o,
  output logic        rob_empty_o,
  output logic [31:0] commit_cnt_o,
  output logic [31:0] flush_cnt_o
);

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;
  logic [PTR_W-1:0] r_br_idx;
  logic             r_br_pending;
  p_reg_t           r_commit;

  logic [DEPTH-1:0] w_valid;
  logic [DEPTH-1:0] w_done;
  logic [DEPTH-1:0] w_has_rd;
  logic [5:0]       w_pdest [DEPTH];

  logic             w_pop;
  logic             w_resolve;
  logic             w_squash;
  logic             w_enq;
  logic             w_enq_has_rd;
  logic [PTR_W-1:0] w_head_post;
  logic [PTR_W-1:0] w_br_off;
  logic [PTR_W:0]   w_count_post;
  logic [PTR_W:0]   w_keep_cnt;

  assign rob_full_o   = (r_count == (PTR_W+1)'(DEPTH));
  assign rob_empty_o  = (r_count == '0);
  assign p_commit_o   = r_commit;

  assign w_pop        = w_valid[r_head] && w_done[r_head];
  assign w_resolve    = br_result_i.valid && r_br_pending;
  assign w_squash     = w_resolve && !br_result_i.hit;
  assign w_enq        = rinstr_i.valid && !rob_full_o && !w_squash;
  assign w_enq_has_rd = rinstr_i.rd.valid && (rinstr_i.rd.idx != '0);

  // After a squash the survivors are exactly post-commit head .. br_idx inclusive.
  assign w_head_post  = r_head + PTR_W'(w_pop);
  assign w_br_off     = r_br_idx - r_head;
  assign w_count_post = r_count - (PTR_W+1)'(w_pop);
  assign w_keep_cnt   = {1'b0, r_br_idx - w_head_post} + (PTR_W+1)'(1);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
    localparam logic [PTR_W-1:0] IDX = PTR_W'(gi);

    logic             r_valid;
    logic             r_done;
    logic             r_has_rd;
    logic             r_is_br;
    logic [5:0]       r_pdest;
    logic [PTR_W-1:0] w_off;
    logic             w_kill;
    logic             w_wb_hit;
    logic             w_br_hit;

    assign w_off    = IDX - r_head;
    assign w_kill   = w_squash && (w_off > w_br_off);
    assign w_wb_hit = wb_i.valid && r_valid && r_has_rd && (r_pdest == wb_i.idx);
    assign w_br_hit = w_resolve && (r_br_idx == IDX) && r_is_br;

    assign w_valid[gi]  = r_valid;
    assign w_done[gi]   = r_done;
    assign w_has_rd[gi] = r_has_rd;
    assign w_pdest[gi]  = r_pdest;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_valid  <= 1'b0;
        r_done   <= 1'b0;
        r_has_rd <= 1'b0;
        r_is_br  <= 1'b0;
        r_pdest  <= '0;
      end else if (w_enq && (r_tail == IDX)) begin
        r_valid  <= 1'b1;
        r_done   <= !w_enq_has_rd && !is_branch_i;
        r_has_rd <= w_enq_has_rd;
        r_is_br  <= is_branch_i;
        r_pdest  <= rinstr_i.rd.idx;
      end else if (w_kill || (w_pop && (r_head == IDX))) begin
        r_valid  <= 1'b0;
        r_done   <= 1'b0;
      end else if (w_wb_hit || w_br_hit) begin
        r_done   <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_br_idx     <= '0;
      r_br_pending <= 1'b0;
      r_commit     <= '0;
    end else begin
      r_head  <= w_head_post;
      r_tail  <= w_squash ? (r_br_idx + PTR_W'(1)) : (r_tail + PTR_W'(w_enq));
      r_count <= w_squash ? w_keep_cnt : (w_count_post + (PTR_W+1)'(w_enq));
      // A resolve and a fresh branch enqueue may land on the same edge.
      if (w_resolve)
        r_br_pending <= 1'b0;
      if (w_enq && is_branch_i) begin
        r_br_pending <= 1'b1;
        r_br_idx     <= r_tail;
      end
      r_commit.valid <= w_pop && w_has_rd[r_head];
      r_commit.idx   <= w_pop ? w_pdest[r_head] : '0;
    end
  end

`ifdef ROB_PERF_CNT_EN
  logic [31:0]    r_commit_cnt;
  logic [31:0]    r_flush_cnt;
  logic [PTR_W:0] w_flush_n;

  assign w_flush_n = w_count_post - w_keep_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_commit_cnt <= '0;
      r_flush_cnt  <= '0;
    end else begin
      if (w_pop)
        r_commit_cnt <= r_commit_cnt + 32'd1;
      if (w_squash)
        r_flush_cnt <= r_flush_cnt + 32'(w_flush_n);
    end
  end

  assign commit_cnt_o = r_commit_cnt;
  assign flush_cnt_o  = r_flush_cnt;
`else
  assign commit_cnt_o = '0;
  assign flush_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_rob_commit.sv
// Self-checking bench for rob_commit: table vectors, directed corner sequences
// and random traffic against a queue-based reference model.
module tb_rob_commit;
  import rob_commit_pkg::*;

  localparam int DEPTH = 16;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  rinstr_t     rinstr_i = '0;
  logic        is_branch_i = 1'b0;
  p_reg_t      wb_i = '0;
  br_result_t  br_result_i = '0;
  p_reg_t      p_commit_o;
  logic        rob_full_o;
  logic        rob_empty_o;
  logic [31:0] commit_cnt_o;
  logic [31:0] flush_cnt_o;

  rob_commit #(.DEPTH(DEPTH)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .rinstr_i     (rinstr_i),
    .is_branch_i  (is_branch_i),
    .wb_i         (wb_i),
    .br_result_i  (br_result_i),
    .p_commit_o   (p_commit_o),
    .rob_full_o   (rob_full_o),
    .rob_empty_o  (rob_empty_o),
    .commit_cnt_o (commit_cnt_o),
    .flush_cnt_o  (flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: program-ordered queue of in-flight instructions.
  typedef struct {
    logic       has_rd;
    logic [5:0] pdest;
    logic       is_br;
    logic       done;
    logic       pend;
  } ent_t;

  typedef struct {
    logic       rv;
    logic       rdv;
    logic [5:0] rdi;
    logic       br;
    logic       wbv;
    logic [5:0] wbi;
    logic       exp_cv;
    logic [5:0] exp_ci;
    logic       exp_empty;
    logic       exp_full;
  } vec_t;

  ent_t        mq[$];
  logic [5:0]  obs[$];
  int unsigned m_commits;
  int unsigned m_flushed;
  int          total = 0;
  int          bad = 0;
  vec_t        tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pend_pos();
    for (int i = 0; i < mq.size(); i++)
      if (mq[i].pend) return i;
    return -1;
  endfunction

  task automatic cycle(input logic rv, input logic rdv, input logic [5:0] rdi, input logic br,
                       input logic wbv, input logic [5:0] wbi, input logic bv, input logic hit);
    logic       pop, squash, enq, exp_cv;
    logic [5:0] exp_ci;
    int         pp;
    ent_t       e;
    rinstr_i.valid    = rv;
    rinstr_i.rd.valid = rdv;
    rinstr_i.rd.idx   = rdi;
    is_branch_i       = br;
    wb_i.valid        = wbv;
    wb_i.idx          = wbi;
    br_result_i.valid = bv;
    br_result_i.hit   = hit;

    pop    = (mq.size() > 0) && mq[0].done;
    pp     = pend_pos();
    squash = bv && (pp >= 0) && !hit;
    enq    = rv && (mq.size() < DEPTH) && !squash;
    exp_cv = pop && mq[0].has_rd;
    exp_ci = pop ? mq[0].pdest : 6'd0;
    if (wbv)
      foreach (mq[i])
        if (mq[i].has_rd && mq[i].pdest == wbi) mq[i].done = 1'b1;
    if (bv && pp >= 0) begin
      mq[pp].done = 1'b1;
      mq[pp].pend = 1'b0;
      if (!hit) begin
        m_flushed += mq.size() - 1 - pp;
        while (mq.size() > pp + 1) void'(mq.pop_back());
      end
    end
    if (pop) begin
      void'(mq.pop_front());
      m_commits++;
    end
    if (enq) begin
      e.has_rd = rdv && (rdi != 6'd0);
      e.pdest  = rdi;
      e.is_br  = br;
      e.done   = !e.has_rd && !br;
      e.pend   = br;
      mq.push_back(e);
    end

    @(posedge clk_i);
    #1;
    chk("commit_valid", p_commit_o.valid, exp_cv);
    if (exp_cv) chk("commit_idx", p_commit_o.idx, exp_ci);
    chk("full", rob_full_o, mq.size() == DEPTH);
    chk("empty", rob_empty_o, mq.size() == 0);
`ifdef ROB_PERF_CNT_EN
    chk("commit_cnt", commit_cnt_o, m_commits);
    chk("flush_cnt", flush_cnt_o, m_flushed);
`else
    chk("commit_cnt", commit_cnt_o, 0);
    chk("flush_cnt", flush_cnt_o, 0);
`endif
    if (p_commit_o.valid) begin
      obs.push_back(p_commit_o.idx);
      $display("commit p%0d", p_commit_o.idx);
    end
    rinstr_i = '0;
    is_branch_i = 1'b0;
    wb_i = '0;
    br_result_i = '0;
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic enq_rd(input logic [5:0] p);
    cycle(1, 1, p, 0, 0, 0, 0, 0);
  endtask

  task automatic wb(input logic [5:0] p);
    cycle(0, 0, 0, 0, 1, p, 0, 0);
  endtask

  // Writes back the youngest outstanding result each cycle so completion is out of order.
  task automatic drain();
    int   sel;
    logic hit_br;
    for (int n = 0; n < 300 && mq.size() > 0; n++) begin
      sel = -1;
      hit_br = pend_pos() >= 0;
      for (int i = mq.size() - 1; i >= 0; i--)
        if (mq[i].has_rd && !mq[i].done) begin sel = i; break; end
      if (sel >= 0) cycle(0, 0, 0, 0, 1, mq[sel].pdest, hit_br, 1);
      else          cycle(0, 0, 0, 0, 0, 0, hit_br, 1);
    end
    chk("drain_empty", rob_empty_o, 1);
  endtask

  task automatic model_reset();
    mq.delete();
    m_commits = 0;
    m_flushed = 0;
  endtask

  initial begin
    logic       rv, rdv, br, wbv, bv, hit;
    logic [5:0] rdi, wbi;
    int         k;

    tbl[0] = '{1, 1, 33, 0, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{1, 1, 34, 0, 0, 0, 0, 0, 0, 0};
    tbl[2] = '{1, 0, 0,  0, 0, 0, 0, 0, 0, 0};
    tbl[3] = '{0, 0, 0,  0, 1, 34, 0, 0, 0, 0};
    tbl[4] = '{0, 0, 0,  0, 1, 33, 0, 0, 0, 0};
    tbl[5] = '{0, 0, 0,  0, 0, 0, 1, 33, 0, 0};
    tbl[6] = '{0, 0, 0,  0, 0, 0, 1, 34, 0, 0};
    tbl[7] = '{0, 0, 0,  0, 0, 0, 0, 0, 1, 0};
    tbl[8] = '{0, 0, 0,  0, 0, 0, 0, 0, 1, 0};

    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_empty", rob_empty_o, 1);
    chk("rst_full", rob_full_o, 0);
    chk("rst_commit", p_commit_o.valid, 0);
    chk("rst_commit_cnt", commit_cnt_o, 0);
    chk("rst_flush_cnt", flush_cnt_o, 0);
    rst_ni = 1'b1;

    // Three instructions, out-of-order writeback, in-order retirement.
    foreach (tbl[i]) begin
      cycle(tbl[i].rv, tbl[i].rdv, tbl[i].rdi, tbl[i].br, tbl[i].wbv, tbl[i].wbi, 0, 0);
      chk($sformatf("tbl%0d_cv", i), p_commit_o.valid, tbl[i].exp_cv);
      if (tbl[i].exp_cv) chk($sformatf("tbl%0d_ci", i), p_commit_o.idx, tbl[i].exp_ci);
      chk($sformatf("tbl%0d_empty", i), rob_empty_o, tbl[i].exp_empty);
      chk($sformatf("tbl%0d_full", i), rob_full_o, tbl[i].exp_full);
    end

    // Fill to full; full blocks enqueue even on the pop edge; tail wraps.
    obs.delete();
    for (int i = 1; i <= DEPTH; i++) enq_rd(6'(i));
    chk("full_at_16", rob_full_o, 1);
    enq_rd(17);
    chk("full_17th_rejected", rob_full_o, 1);
    cycle(1, 1, 17, 0, 1, 1, 0, 0);
    chk("full_wb_edge", rob_full_o, 1);
    enq_rd(17);
    chk("full_after_pop", rob_full_o, 0);
    chk("pop_p1", p_commit_o.idx, 1);
    enq_rd(17);
    chk("full_after_wrap", rob_full_o, 1);
    drain();
    chk("full_seq_len", obs.size(), 17);
    foreach (obs[i]) chk($sformatf("full_seq%0d", i), obs[i], i + 1);

    // Mispredict: p41/p42 squashed, two survivors verified by refilling to full.
    obs.delete();
    enq_rd(40);
    cycle(1, 0, 0, 1, 0, 0, 0, 0);
    enq_rd(41);
    enq_rd(42);
    cycle(1, 1, 50, 0, 0, 0, 1, 0);
    for (int i = 0; i < 13; i++) enq_rd(6'(20 + i));
    chk("squash_13_not_full", rob_full_o, 0);
    enq_rd(33);
    chk("squash_14_full", rob_full_o, 1);
    wb(41);
    wb(40);
    idle();
    drain();
    chk("squash_seq_len", obs.size(), 15);
    chk("squash_first", obs[0], 40);
    chk("squash_second", obs[1], 20);

    // Correct prediction: nothing squashed.
    obs.delete();
    enq_rd(40);
    cycle(1, 0, 0, 1, 0, 0, 0, 0);
    enq_rd(41);
    enq_rd(42);
    cycle(0, 0, 0, 0, 0, 0, 1, 1);
    wb(40);
    wb(41);
    wb(42);
    drain();
    chk("hit_seq_len", obs.size(), 3);
    for (int i = 0; i < 3; i++) chk($sformatf("hit_seq%0d", i), obs[i], 40 + i);

    // Asynchronous reset with five entries in flight.
    for (int i = 0; i < 5; i++) enq_rd(6'(10 + i));
    wb(10);
    rst_ni = 1'b0;
    @(posedge clk_i);
    #1;
    chk("mid_rst_empty", rob_empty_o, 1);
    chk("mid_rst_full", rob_full_o, 0);
    chk("mid_rst_commit", p_commit_o.valid, 0);
    chk("mid_rst_commit_cnt", commit_cnt_o, 0);
    chk("mid_rst_flush_cnt", flush_cnt_o, 0);
    model_reset();
    #2;
    rst_ni = 1'b1;

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      rv  = $urandom_range(0, 9) < 6;
      rdv = $urandom_range(0, 3) != 0;
      rdi = 6'($urandom_range(0, 63));
      br  = rv && (pend_pos() < 0) && ($urandom_range(0, 5) == 0);
      if (br) rdv = 1'b0;
      wbv = 1'b0;
      wbi = 6'd0;
      k = $urandom_range(0, 3);
      if (k < 2 && mq.size() > 0) begin
        k = $urandom_range(0, mq.size() - 1);
        if (mq[k].has_rd && !mq[k].done) begin wbv = 1'b1; wbi = mq[k].pdest; end
      end else if (k == 2) begin
        wbv = 1'b1;
        wbi = 6'($urandom_range(0, 63));
      end
      bv  = (pend_pos() >= 0) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 19) == 0);
      hit = 1'($urandom_range(0, 1));
      cycle(rv, rdv, rdi, br, wbv, wbi, bv, hit);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
